// File: rtl/jogo_defs_pkg.sv
// Shared game definitions: display sequencer state encodings and debug codes.
// The db_estado codes are what the top-level HEX decoders show, so they must
// stay aligned with the unidade_controle numbering.
package jogo_defs_pkg;

  localparam int unsigned ESTADO_W = 3;
  localparam int unsigned DB_W     = 4;

  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO    = 3'd0,
    CARREGA   = 3'd1,
    MOSTRA    = 3'd2,
    INTERVALO = 3'd3,
    AVANCA    = 3'd4,
    FIM       = 3'd5
  } estado_e;

  // Debug code shown on the HEX display for a given state.
  function automatic logic [DB_W-1:0] estado_db(input estado_e e);
    return {1'b0, e};
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/contador_intervalo.sv
// Interval counter used as the ON/OFF timer.
// Ports:
//   clock, reset : clock, async active-high reset
//   zera_i       : synchronous clear, wins over conta_i
//   conta_i      : count enable
//   valor_o      : current count
//   fim_o        : count is at M-1
module contador_intervalo #(
  parameter int unsigned M = 4,
  parameter int unsigned W = $clog2(M + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera_i,
  input  logic         conta_i,
  output logic [W-1:0] valor_o,
  output logic         fim_o
);

  logic [W-1:0] valor_q;
  logic [W-1:0] valor_d;

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) valor_q <= '0;
    else       valor_q <= valor_d;
  end

  // Clear takes priority over counting.
  always_comb begin
    valor_d = valor_q;
    if (zera_i)       valor_d = '0;
    else if (conta_i) valor_d = valor_q + W'(1);
  end

  assign valor_o = valor_q;
  assign fim_o   = (valor_q == W'(M - 1));

endmodule

// File: rtl/sequenciador_exibicao.sv
// Display sequencer: walks memory addresses 0..limite, lighting each word on
// the LEDs for ON_CYCLES clocks followed by OFF_CYCLES dark clocks, then pulses
// pronto. Sits between unidade_controle (iniciar/pronto) and the memory/LED path.
// Ports:
//   clock, reset : clock, async active-high reset
//   iniciar      : start request (only honoured when idle)
//   abortar      : synchronous abort, highest priority
//   limite       : last address to show, captured at start
//   dado_mem     : async-read memory word at endereco
//   endereco     : memory read address
//   leds         : LED drive
//   exibindo     : high whenever not idle
//   pronto       : one-cycle pulse when the whole sequence has been shown
//   db_estado    : debug state code
module sequenciador_exibicao
  import jogo_defs_pkg::*;
#(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned ON_CYCLES  = 500,
  parameter int unsigned OFF_CYCLES = 250
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] dado_mem,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              exibindo,
  output logic              pronto,
  output logic [DB_W-1:0]   db_estado
);

  localparam int unsigned T_MAX = max_u(ON_CYCLES, OFF_CYCLES);
  localparam int unsigned TW    = $clog2(T_MAX + 1);

  estado_e           estado_q, estado_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] limite_q, limite_d;
  logic [DATA_W-1:0] dado_q, dado_d;
  logic [DATA_W-1:0] leds_q, leds_d;
  logic              exibindo_q, exibindo_d;
  logic              pronto_q, pronto_d;
  logic [DB_W-1:0]   db_q, db_d;

  logic [TW-1:0]     timer;
  logic              timer_fim;
  logic              timer_zera;
  logic              timer_conta;

  // Timer is cleared on every state change; saturation guard keeps it from wrapping.
  assign timer_zera  = (estado_d != estado_q);
  assign timer_conta = ((estado_q == MOSTRA) || (estado_q == INTERVALO)) && !timer_fim;

  contador_intervalo #(
    .M (T_MAX),
    .W (TW)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .zera_i  (timer_zera),
    .conta_i (timer_conta),
    .valor_o (timer),
    .fim_o   (timer_fim)
  );

  // State, datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      endereco_q <= '0;
      limite_q   <= '0;
      dado_q     <= '0;
      leds_q     <= '0;
      exibindo_q <= 1'b0;
      pronto_q   <= 1'b0;
      db_q       <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      dado_q     <= dado_d;
      leds_q     <= leds_d;
      exibindo_q <= exibindo_d;
      pronto_q   <= pronto_d;
      db_q       <= db_d;
    end
  end

  // Next-state logic; outputs are registered from the next state so they
  // behave as Moore outputs of the state being entered.
  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    limite_d   = limite_q;
    dado_d     = dado_q;

    case (estado_q)
      OCIOSO: begin
        endereco_d = '0;
        if (iniciar && !abortar) begin
          estado_d = CARREGA;
          limite_d = limite;
        end
      end
      CARREGA: begin
        dado_d   = dado_mem;
        estado_d = MOSTRA;
      end
      MOSTRA: begin
        if (timer == TW'(ON_CYCLES - 1)) estado_d = INTERVALO;
      end
      INTERVALO: begin
        // Compare before increment so the last address never wraps to 0.
        if (timer == TW'(OFF_CYCLES - 1))
          estado_d = (endereco_q == limite_q) ? FIM : AVANCA;
      end
      AVANCA: begin
        endereco_d = endereco_q + ADDR_W'(1);
        estado_d   = CARREGA;
      end
      FIM: begin
        endereco_d = '0;
        estado_d   = OCIOSO;
      end
      default: begin
        endereco_d = '0;
        estado_d   = OCIOSO;
      end
    endcase

    if (abortar) begin
      estado_d   = OCIOSO;
      endereco_d = '0;
    end

    leds_d     = (estado_d == MOSTRA) ? dado_d : '0;
    exibindo_d = (estado_d != OCIOSO);
    pronto_d   = (estado_d == FIM);
    db_d       = estado_db(estado_d);
  end

  assign endereco  = endereco_q;
  assign leds      = leds_q;
  assign exibindo  = exibindo_q;
  assign pronto    = pronto_q;
  assign db_estado = db_q;

endmodule
